// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   SIZE_WORD  : sram-like transfer size code for a 32-bit word
//   PC_STEP    : sequential fetch increment
//   iq_entry_t : instruction queue entry {pc, inst}
//   ptr_w/idx_w: pointer and storage-index widths for a FIFO of a given depth
package inst_prefetch_pkg;

  localparam logic [1:0]  SIZE_WORD = 2'd2;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam int unsigned ENTRY_W = $bits(iq_entry_t);

  // Read/write pointers carry one extra wrap bit above the index.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

  // Storage index width; never zero so a depth-1 FIFO still has an index bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Read-only instruction sram-like bus between the prefetch queue and the
// CPU<->AXI bridge.
//   master : prefetch side (drives req/wr/size/addr/wdata)
//   slave  : bridge side   (drives rdata/addr_ok/data_ok)
interface inst_prefetch_queue_if;

  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok
  );

endinterface

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// sync_fifo: synchronous FIFO with synchronous flush.
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : empty the FIFO this cycle (wins over push/pop)
//   push, wdata : write request and data (accepted when not full, or full with pop)
//   pop         : remove head entry (ignored when empty)
//   rdata       : head entry (combinational)
//   count       : number of stored entries
module sync_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [ptr_w(DEPTH)-1:0]   count
);

  localparam int unsigned PW    = ptr_w(DEPTH);
  localparam int unsigned IW    = idx_w(DEPTH);
  localparam int unsigned SLOTS = 1 << IW;
  localparam logic [PW-1:0] WRAP_ONLY = PW'(1) << (PW - 1);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Full: wrap bits differ while the index bits match.
  assign full    = ((wr_ptr ^ rd_ptr) == WRAP_ONLY);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[IW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches on the inst
// sram-like bus, tracks outstanding reads, and buffers {pc, inst} pairs for
// decode. A redirect flushes the queue, restarts fetch at redirect_pc and
// drops every response still owed to the old path.
//   clk, resetn                 : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc : flush and restart fetch
//   deq_valid/deq_ready         : head-entry handshake to decode
//   deq_inst, deq_pc            : head entry (0 when empty)
//   bus                         : inst sram-like master port
// Optional build macro INST_BYPASS_EN: a response arriving while the queue is
// empty is presented on deq_* in the same cycle.
module inst_prefetch_queue
  import inst_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [31:0]            deq_inst,
  output logic [31:0]            deq_pc,
  inst_prefetch_queue_if.master  bus
);

  localparam int unsigned OW = ptr_w(MAX_OUTST);
  localparam int unsigned QW = ptr_w(QDEPTH);

  logic            run;
  logic [31:0]     fetch_pc;
  logic [31:0]     held_pc;
  logic            hold;
  logic            hold_stale;
  logic [OW-1:0]   discard;
  logic [OW-1:0]   outst;
  logic [QW-1:0]   qcount;
  logic [31:0]     opc_head;
  iq_entry_t       q_head;
  iq_entry_t       q_wdata;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            can_issue;
  logic            accept;
  logic            rsp;
  logic            drop;

  // The outstanding-PC FIFO occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_opc_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (1'b0),
    .push   (accept),
    .wdata  (bus.inst_addr),
    .pop    (rsp),
    .rdata  (opc_head),
    .count  (outst)
  );

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_inst_queue (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect_valid),
    .push   (q_push),
    .wdata  (q_wdata),
    .pop    (q_pop),
    .rdata  (q_head),
    .count  (qcount)
  );

  // run keeps inst_req low while in reset and for the first cycle after it.
  assign can_issue = run
                  && (32'(outst) < MAX_OUTST)
                  && ((32'(outst) + 32'(qcount)) < QDEPTH)
                  && !redirect_valid;

  assign bus.inst_req   = hold | can_issue;
  assign bus.inst_addr  = hold ? held_pc : fetch_pc;
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = SIZE_WORD;
  assign bus.inst_wdata = '0;

  assign accept  = bus.inst_req && bus.inst_addr_ok;
  assign rsp     = bus.inst_data_ok;
  // A response in the redirect cycle belongs to the old path as well.
  assign drop    = rsp && (redirect_valid || (discard != '0));
  assign q_empty = (qcount == '0);
  assign q_pop   = !q_empty && deq_ready;
  assign q_wdata = '{pc: opc_head, inst: bus.inst_rdata};

  always_comb begin
    deq_valid = !q_empty;
    deq_pc    = '0;
    deq_inst  = '0;
    q_push    = rsp && !drop;
    if (!q_empty) begin
      deq_pc   = q_head.pc;
      deq_inst = q_head.inst;
    end
`ifdef INST_BYPASS_EN
    else if (rsp && !drop) begin
      deq_valid = 1'b1;
      deq_pc    = opc_head;
      deq_inst  = bus.inst_rdata;
      q_push    = !deq_ready;
    end
`endif
  end

  // hold_stale marks a held request that predates a redirect: when it is
  // finally accepted it must be discarded and must not advance fetch_pc.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run        <= 1'b0;
      fetch_pc   <= RESET_PC;
      held_pc    <= '0;
      hold       <= 1'b0;
      hold_stale <= 1'b0;
      discard    <= '0;
    end else begin
      run <= 1'b1;
      if (bus.inst_req && !bus.inst_addr_ok) begin
        hold    <= 1'b1;
        held_pc <= bus.inst_addr;
      end else if (accept) begin
        hold <= 1'b0;
      end
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc;
        discard    <= outst + OW'(accept) - OW'(rsp);
        hold_stale <= hold && !accept;
      end else begin
        if (accept && !hold_stale) fetch_pc <= fetch_pc + PC_STEP;
        if (accept) hold_stale <= 1'b0;
        discard <= discard + OW'(accept && hold_stale)
                           - OW'(rsp && (discard != '0));
      end
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;
  import inst_prefetch_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam int unsigned QD  = 4;
  localparam int unsigned MO  = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;

  inst_prefetch_queue_if bus();

  inst_prefetch_queue #(
    .RESET_PC  (RPC),
    .QDEPTH    (QD),
    .MAX_OUTST (MO)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_inst       (deq_inst),
    .deq_pc         (deq_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    int          ep;
    int          cyc;
  } req_t;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          epoch = 0;
  req_t        slv_q[$];
  iq_entry_t   model_q[$];
  logic [31:0] exp_addr = RPC;
  bit          stale = 1'b0;
  logic [31:0] stale_addr = '0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  // Contents of instruction memory as seen by the bench slave.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rv, input logic [31:0] rpc, input bit dr,
                       input bit aok, input bit want_rsp);
    redirect_valid   = rv;
    redirect_pc      = rpc;
    deq_ready        = dr;
    bus.inst_addr_ok = aok;
    if (want_rsp && slv_q.size() != 0 && slv_q[0].cyc < cyc) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = mem_word(slv_q[0].addr);
    end else begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = '0;
    end
  endtask

  // One clock: sample at the falling edge, update the reference model with
  // this cycle's bus events, then advance to just after the rising edge.
  task automatic step();
    logic acc;
    logic rsp;
    req_t r;
    @(negedge clk);
    acc = bus.inst_req && bus.inst_addr_ok;
    rsp = bus.inst_data_ok;
    chk("deq_valid", 32'(deq_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk("deq_pc", deq_pc, model_q[0].pc);
      chk("deq_inst", deq_inst, model_q[0].inst);
    end
    if (prev_pending) begin
      chk("hold_req", 32'(bus.inst_req), 32'd1);
      chk("hold_addr", bus.inst_addr, prev_addr);
    end
    if (acc) begin
      r.addr = bus.inst_addr;
      r.cyc  = cyc;
      if (stale) begin
        r.pc  = stale_addr;
        r.ep  = -1;
        stale = 1'b0;
      end else begin
        r.pc     = exp_addr;
        r.ep     = epoch;
        exp_addr = exp_addr + 32'd4;
      end
      chk("req_addr", bus.inst_addr, r.pc);
      slv_q.push_back(r);
    end
    if (deq_valid && deq_ready && model_q.size() != 0) void'(model_q.pop_front());
    if (rsp) begin
      r = slv_q.pop_front();
      if (!redirect_valid && r.ep == epoch)
        model_q.push_back(iq_entry_t'{pc: r.pc, inst: mem_word(r.pc)});
    end
    if (redirect_valid) begin
      if (bus.inst_req && !acc) begin
        if (!stale) stale_addr = exp_addr;
        stale = 1'b1;
      end
      exp_addr = redirect_pc;
      epoch++;
      model_q.delete();
    end
    chk("outst_bound", 32'(slv_q.size() <= MO), 32'd1);
    chk("queue_bound", 32'(model_q.size() <= QD), 32'd1);
    prev_pending = bus.inst_req && !bus.inst_addr_ok;
    prev_addr    = bus.inst_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    chk("rst_inst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_pc", deq_pc, 32'd0);
    chk("rst_deq_inst", deq_inst, 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    slv_q.delete();
    model_q.delete();
    exp_addr     = RPC;
    stale        = 1'b0;
    prev_pending = 1'b0;
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("post_rst_deq_valid", 32'(deq_valid), 32'd0);
  endtask

  initial begin
    int pops;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    #1;

    // Reset, then steady sequential stream with immediate acceptance.
    apply_reset();
    repeat (30) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Decode stalled: queue fills to QDEPTH and requests stop.
    repeat (20) begin drive(1'b0, '0, 1'b0, 1'b1, 1'b1); step(); end
    chk("stall_req_low", 32'(bus.inst_req), 32'd0);
    chk("stall_valid", 32'(deq_valid), 32'd1);
    pops = 0;
    repeat (8) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      if (deq_valid) pops++;
      step();
    end
    chk("drain_count", 32'(pops), 32'd4);
    repeat (6) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Address phase stalled on the third fetch.
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (exp_addr == RPC + 32'd8) break;
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step();
      chk("held_req", 32'(bus.inst_req), 32'd1);
      chk("held_addr", bus.inst_addr, 32'hBFC0_0008);
    end
    repeat (10) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Redirect with two reads outstanding.
    for (int i = 0; i < 10; i++) begin
      if (slv_q.size() == 2) break;
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk("two_outstanding", 32'(slv_q.size()), 32'd2);
    drive(1'b1, 32'h8000_1000, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
      if (deq_valid) break;
      step();
    end
    chk("redirect_first_pc", deq_pc, 32'h8000_1000);
    repeat (8) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Redirect while a request is held unaccepted.
    repeat (3) begin drive(1'b0, '0, 1'b1, 1'b0, 1'b1); step(); end
    chk("pre_redirect_hold", 32'(bus.inst_req), 32'd1);
    drive(1'b1, 32'h8000_2000, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step();
    repeat (12) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Fetch address wrap-around.
    drive(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1);
    step();
    repeat (15) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Reset in the middle of a burst.
    for (int i = 0; i < 6; i++) begin
      if (slv_q.size() == 2) break;
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk("burst_outstanding", 32'(slv_q.size()), 32'd2);
    apply_reset();
    repeat (10) begin drive(1'b0, '0, 1'b1, 1'b1, 1'b1); step(); end

    // Randomised traffic against the reference model.
    repeat (1500) begin
      drive(($urandom_range(0, 99) < 3), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 60));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the CPU↔AXI bridge's inst sram-like port.
- Generates sequential fetch addresses, issues read-only inst sram-like requests, and tracks outstanding reads.
- Buffers returned instructions, each tagged with its PC, in a small FIFO consumed by decode.
- Handles branch/exception redirects by flushing the queue and dropping stale in-flight responses.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- QDEPTH, 4, instruction queue entries (power of two, ≥2).
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (power of two, ≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  flush and restart fetch this cycle.
- redirect_pc  in  32  new fetch address (word-aligned).
- deq_ready  in  1  decode accepts the head entry.
- deq_valid  out  1  head entry valid.
- deq_inst  out  32  head instruction.
- deq_pc  out  32  head PC.
- inst_req  out  1  sram-like request.
- inst_wr  out  1  tied to 0.
- inst_size  out  2  tied to 2'd2 (word).
- inst_addr  out  32  fetch address.
- inst_wdata  out  32  tied to 0.
- inst_rdata  in  32  returned instruction.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  response valid (in order).

Behaviour:
- **Reset (resetn=0, asynchronous):**
  - fetch_pc=RESET_PC; outst=0; discard=0; queue empty; hold=0.
  - Outputs: inst_req=0, deq_valid=0, deq_inst=0, deq_pc=0.
- **Credit.** can_issue = (outst < MAX_OUTST) && (outst + qcount < QDEPTH) && !redirect_valid.
  - Counts use the registered values.
  - The queue can never overflow.
- **Request.**
  - inst_req = hold | can_issue.
  - inst_addr = hold ? held_pc : fetch_pc.
- **Hold rule.** If inst_req=1 and inst_addr_ok=0:
  - hold<=1 and held_pc<=inst_addr.
  - inst_req/inst_addr stay stable until accepted; a request is never withdrawn, even on redirect.
- **Accept.** inst_req && inst_addr_ok:
  - outst+1.
  - The address is pushed into the outstanding-PC FIFO (depth MAX_OUTST).
  - hold<=0.
  - fetch_pc += 4, unless the request came from hold after a redirect; see below.
- **Response.** inst_data_ok pops the outstanding-PC FIFO and decrements outst.
  - If discard>0: discard-1, data dropped.
  - Otherwise push {popped_pc, inst_rdata} into the queue.
- **Simultaneous accept and response:** outst unchanged.
- **Redirect.** redirect_valid=1 in cycle T:
  - Queue flushed at end of T.
  - fetch_pc <= redirect_pc.
  - discard <= outst + (accept in T) − (data_ok in T); a data_ok in T is itself dropped.
  - A held request still pending at T is later accepted, counted into discard, and does not advance fetch_pc.
  - First new-path request no earlier than T+1.
- **Dequeue.** deq_valid = queue not empty; pop on deq_valid && deq_ready.
  - Push and pop in the same cycle is legal when full or empty.
  - If redirect and pop occur in the same cycle, the pop completes and the flush wins: queue empty at T+1.
- **Wrap-around.**
  - fetch_pc + 4 wraps modulo 2^32.
  - Queue/FIFO pointers are log2(depth)+1 bits; full when MSBs differ and the low bits match.
- **Latency.** With addr_ok=1 in the same cycle and data_ok one cycle later, the instruction is visible on deq two cycles after request.

Optional Feature:
- INST_BYPASS_EN defined:
  - When the queue is empty and a non-discarded data_ok arrives, deq_valid/deq_inst/deq_pc are driven combinationally from the response that cycle.
  - If deq_ready=1, the entry is not written to the queue.
  - Minimum latency drops by one cycle.
- Undefined: every response goes through the queue (registered output path only).

Decomposition:
- Package inst_prefetch_pkg holds:
  - constants SIZE_WORD=2'd2 and PC_STEP=32'd4;
  - typedef of the queue entry struct {pc[31:0], inst[31:0]};
  - localparam helpers for pointer widths.
- One natural sub-module: sync_fifo (parameterised width/depth with flush input), instantiated twice:
  - instruction queue;
  - outstanding-PC FIFO.

Test Plan:
- Reset release, addr_ok=1 always, data_ok one cycle after each accept, deq_ready=1 → requests 0xBFC00000, 0xBFC00004, …; deq_pc sequence matches; outst never exceeds 2.
- deq_ready=0 for 20 cycles → exactly 4 entries queued; inst_req drops once outst+qcount=4; no data lost after deq_ready=1.
- addr_ok=0 for 3 cycles → inst_req and inst_addr=0xBFC00008 held stable across all 3 cycles; fetch_pc advances only on acceptance.
- Redirect to 0x80001000 with 2 outstanding → both responses dropped (deq_valid stays 0); next deq_pc=0x80001000.
- Redirect while a request is held unaccepted → held request issued unchanged, its data discarded; following request addr=redirect_pc.
- Assert resetn=0 mid-burst with 2 outstanding → outputs clear immediately; after release the first request is RESET_PC and deq_valid=0.
